// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the registered ALU pipeline (opcodes, FSM states,
// status-flag bundle).
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_MUL = 3'b110,
        OP_SRA = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one bit of b per cycle.
// start loads the operands; done pulses on the cycle the last bit is
// consumed, with prod_lo/prod_hi_nz valid combinationally in that cycle.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic             prod_hi_nz
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    // {hi,lo} holds partial product in the upper half and the unconsumed
    // multiplier bits in the lower half; each step adds and shifts right.
    assign sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {WIDTH{1'b0}})};
    assign hi_d = sum[WIDTH:1];
    assign lo_d = {sum[0], lo_q[WIDTH-1:1]};

    assign done       = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign prod_lo    = lo_d;
    assign prod_hi_nz = |hi_d;

    // Operand capture and per-cycle shift-add step; reset aborts any run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (start) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            mcand_q <= a;
            hi_q    <= '0;
            lo_q    <= b;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready on both sides.
// Optional multiplier enabled by defining ALU_PIPE_MUL_EN; without it,
// opcode 110 completes in one cycle with result 0 and illegal=1.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    op_e              op;
    logic             accept;
    logic             load_alu;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    flags_t           flags_q;
    logic             illegal_q;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    flags_t           alu_flags;
    logic             alu_ill;

    logic             mul_done;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;
    flags_t           mul_flags;

    assign op     = op_e'(opcode);
    assign accept = in_valid && in_ready;
    assign shamt  = b[SHW-1:0];
    assign add_w  = {1'b0, a} + {1'b0, b};
    assign sub_w  = {1'b0, a} - {1'b0, b};

    // Single-cycle datapath: result plus carry/overflow, z/n from result.
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        alu_ill   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res     = add_w[WIDTH-1:0];
                alu_flags.c = add_w[WIDTH];
                alu_flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res     = sub_w[WIDTH-1:0];
                alu_flags.c = ~sub_w[WIDTH];
                alu_flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SLL: alu_res = a << shamt;
            OP_SRA: alu_res = $signed(a) >>> shamt;
            OP_MUL: begin
`ifndef ALU_PIPE_MUL_EN
                alu_ill = 1'b1;
`endif
                alu_res = '0;
            end
            default: alu_res = '0;
        endcase
        alu_flags.z = (alu_res == '0);
        alu_flags.n = alu_res[WIDTH-1];
    end

`ifdef ALU_PIPE_MUL_EN
    state_e state_q, state_d;
    logic   mul_start;

    assign mul_start = accept && (op == OP_MUL);
    assign load_alu  = accept && (op != OP_MUL);
    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: MUL parks in BUSY until the multiplier finishes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mul_start) state_d = S_BUSY;
            S_BUSY:  if (mul_done)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (mul_start),
        .a          (a),
        .b          (b),
        .done       (mul_done),
        .prod_lo    (mul_lo),
        .prod_hi_nz (mul_hi_nz)
    );
`else
    assign load_alu  = accept;
    assign in_ready  = !out_valid_q || out_ready;
    assign mul_done  = 1'b0;
    assign mul_lo    = '0;
    assign mul_hi_nz = 1'b0;
`endif

    // Multiplier completion flags; v is never set for MUL.
    always_comb begin
        mul_flags   = '0;
        mul_flags.z = (mul_lo == '0);
        mul_flags.n = mul_lo[WIDTH-1];
        mul_flags.c = mul_hi_nz;
    end

    // Output register: load on accept or MUL completion, else drain on ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
        end else if (load_alu) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            flags_q     <= alu_flags;
            illegal_q   <= alu_ill;
        end else if (mul_done) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_lo;
            flags_q     <= mul_flags;
            illegal_q   <= 1'b0;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_z    = flags_q.z;
    assign flag_n    = flags_q.n;
    assign flag_c    = flags_q.c;
    assign flag_v    = flags_q.v;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed + random checks of alu_pipe (WIDTH=32) with a
// scoreboard queue. Honors ALU_PIPE_MUL_EN the same way as the RTL.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  opcode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        flag_z, flag_n, flag_c, flag_v, illegal;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    logic [36:0] sb[$];

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [36:0] pk(input logic [31:0] r, input logic z, input logic n,
                                       input logic c, input logic v, input logic il);
        return {r, z, n, c, v, il};
    endfunction

    // Reference model for the random stream and MUL.
    function automatic logic [36:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] wide;
        logic [31:0] r;
        logic        c, v, il;
        c = 1'b0; v = 1'b0; il = 1'b0; r = '0;
        case (op)
            3'd0: begin
                wide = {32'd0, x} + {32'd0, y};
                r = wide[31:0]; c = wide[32];
                v = (x[31] & y[31] & ~r[31]) | (~x[31] & ~y[31] & r[31]);
            end
            3'd1: begin
                r = x - y; c = (x >= y);
                v = (x[31] & ~y[31] & ~r[31]) | (~x[31] & y[31] & r[31]);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = x << y[4:0];
            3'd6: begin
`ifdef ALU_PIPE_MUL_EN
                wide = {32'd0, x} * {32'd0, y};
                r = wide[31:0]; c = (wide[63:32] != 0);
`else
                il = 1'b1;
`endif
            end
            default: begin
                wide = {{32{x[31]}}, x} >> y[4:0];
                r = wide[31:0];
            end
        endcase
        return pk(r, r == 0, r[31], c, v, il);
    endfunction

    // Drive a bundle, wait (bounded) for in_ready, record the expectation.
    task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [36:0] exp);
        int w;
        w = 0;
        opcode = op; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1) begin
            stalls++; w++;
            if (w > 200) begin
                chk("send_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        sb.push_back(exp);
        @(posedge clk); #1;
    endtask

    // Scoreboard: compare every consumed result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) chk("sb_unexpected", 64'd1, 64'd0);
            else chk("sb_result", {27'd0, result, flag_z, flag_n, flag_c, flag_v, illegal}, {27'd0, sb.pop_front()});
        end
    end

    initial begin
        int n;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        // Reset state
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {flag_z, flag_n, flag_c, flag_v, illegal}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        // Directed single-cycle ops
        send(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, pk(32'h0000_0000, 1, 0, 1, 0, 0));
        chk("add_latency", out_valid, 1);
        send(3'd1, 32'h8000_0000, 32'h0000_0001, pk(32'h7FFF_FFFF, 0, 0, 1, 1, 0));
        send(3'd7, 32'hF000_0000, 32'h0000_0024, pk(32'hFF00_0000, 0, 1, 0, 0, 0));
        send(3'd5, 32'h0000_0001, 32'h0000_001F, pk(32'h8000_0000, 0, 1, 0, 0, 0));
        send(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, pk(32'hF000_F000, 0, 1, 0, 0, 0));
        send(3'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5, pk(32'h0000_0000, 1, 0, 0, 0, 0));
        send(3'd7, 32'h4000_0000, 32'hFFFF_FFE2, pk(32'h1000_0000, 0, 0, 0, 0, 0));
        send(3'd1, 32'h0000_0001, 32'h0000_0002, pk(32'hFFFF_FFFF, 0, 1, 0, 0, 0));
        send(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, pk(32'h8000_0000, 0, 1, 0, 1, 0));
        send(3'd3, 32'h0000_0000, 32'h0000_0000, pk(32'h0000_0000, 1, 0, 0, 0, 0));
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure: hold first result, second bundle must wait
        out_ready = 1'b0;
        send(3'd0, 32'd5, 32'd6, pk(32'd11, 0, 0, 0, 0, 0));
        opcode = 3'd0; a = 32'd7; b = 32'd8; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result_hold", result, 32'd11);
            @(posedge clk); #1;
        end
        sb.push_back(pk(32'd15, 0, 0, 0, 0, 0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_reload_valid", out_valid, 1);
        chk("bp_reload_result", result, 32'd15);
        @(posedge clk); #1;

`ifdef ALU_PIPE_MUL_EN
        // MUL latency and busy backpressure
        send(3'd6, 32'h0001_0000, 32'h0001_0000, pk(32'h0000_0000, 1, 0, 1, 0, 0));
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            chk("mul_busy_in_ready", in_ready, 0);
            @(posedge clk); #1;
            n++;
        end
        chk("mul_latency", n, 32);
        send(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, model(3'd6, 32'h1234_5678, 32'h9ABC_DEF0));
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mul2_latency", n, 32);
        @(posedge clk); #1;
        // Start a MUL that reset will abort at count 10
        send(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, pk(32'h0, 0, 0, 0, 0, 0));
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
`else
        // Disabled MUL: single cycle, illegal, z=1
        send(3'd6, 32'd3, 32'd5, pk(32'h0, 1, 0, 0, 0, 1));
        in_valid = 1'b0;
        chk("mul_off_latency", out_valid, 1);
        chk("mul_off_illegal", illegal, 1);
        @(posedge clk); #1;
        // Leave an unconsumed result pending across reset
        out_ready = 1'b0;
        send(3'd0, 32'd1, 32'd1, pk(32'd2, 0, 0, 0, 0, 0));
        in_valid = 1'b0;
`endif

        // Reset mid-operation
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst2_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_out_valid_rel", out_valid, 0);
        out_ready = 1'b1;
        send(3'd0, 32'd2, 32'd3, pk(32'd5, 0, 0, 0, 0, 0));
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Random non-MUL stream, one per cycle
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            rop = 3'($urandom_range(0, 6));
            if (rop == 3'd6) rop = 3'd7;
            ra = $urandom();
            rb = (i % 5 == 0) ? ra : $urandom();
            send(rop, ra, rb, model(rop, ra, rb));
            chk("stream_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        chk("stream_no_bubbles", stalls, 0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
